// File: rtl/adc_sample_scheduler_if.sv
// rtl/adc_sample_scheduler_if.sv - handshake between the sample scheduler and the ADS1115 I2C reader
interface adc_sample_scheduler_if;
   logic        adc_start;
   logic [2:0]  adc_mux;
   logic        adc_done;
   logic [15:0] adc_data;

   modport master (output adc_start, output adc_mux, input adc_done, input adc_data);
   modport slave  (input adc_start, input adc_mux, output adc_done, output adc_data);
endinterface

// File: rtl/adc_sample_scheduler.sv
// rtl/adc_sample_scheduler.sv - per-tick ADC conversion frame sequencer for the MPPT loop
module adc_sample_scheduler #(
   parameter int PERIOD_CYC  = 50000,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   run,
   input  logic [3:0]             ch_mask,
   input  logic                   clr_err,
   adc_sample_scheduler_if.master adc,
   output logic [63:0]            sample_bus,
   output logic                   frame_valid,
   output logic                   frame_ok,
   output logic [15:0]            frame_cnt,
   output logic                   timeout_err,
   output logic [1:0]             err_ch,
   output logic                   overrun_err,
   output logic                   busy
);
   localparam int PW = $clog2(PERIOD_CYC);
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYC - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {IDLE, WAIT_TICK, SELECT, ISSUE, WAIT_DONE, FRAME_END} state_t;

   state_t        state;
   logic [PW-1:0] per_cnt;
   logic [TW-1:0] to_cnt;
   logic [3:0]    mask_q;
   logic [1:0]    ch;
   logic          frame_bad;
   logic          tick;
   logic          done_evt;
   logic          to_evt;
   logic [1:0]    tick_ch;
   logic [1:0]    next_ch;

   function automatic logic [1:0] lowest(input logic [3:0] m);
      if (m[0])      return 2'd0;
      else if (m[1]) return 2'd1;
      else if (m[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   assign tick     = run && (per_cnt == PER_LAST);
   assign done_evt = (state == WAIT_DONE) && adc.adc_done;
   // done in the same cycle as the last wait cycle counts as success
   assign to_evt   = (state == WAIT_DONE) && !adc.adc_done && (to_cnt == TO_LAST);
   assign tick_ch  = lowest(ch_mask);
   assign next_ch  = lowest(mask_q);

   // outputs are registered on entry to the state that owns them, so SELECT
   // work (mux + channel pick) is done on the transition into SELECT
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         per_cnt       <= '0;
         to_cnt        <= '0;
         mask_q        <= 4'b0;
         ch            <= 2'd0;
         frame_bad     <= 1'b0;
         adc.adc_start <= 1'b0;
         adc.adc_mux   <= 3'b000;
         sample_bus    <= 64'b0;
         frame_valid   <= 1'b0;
         frame_ok      <= 1'b0;
         frame_cnt     <= 16'b0;
         timeout_err   <= 1'b0;
         err_ch        <= 2'd0;
         overrun_err   <= 1'b0;
         busy          <= 1'b0;
      end else begin
         adc.adc_start <= 1'b0;
         frame_valid   <= 1'b0;
         frame_ok      <= 1'b0;

         if (!run || tick) per_cnt <= '0;
         else              per_cnt <= per_cnt + 1'b1;

         if (clr_err) begin
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
         end
         if (tick && busy) overrun_err <= 1'b1;

         case (state)
            IDLE: if (run) state <= WAIT_TICK;
            WAIT_TICK: begin
               if (!run) begin
                  state <= IDLE;
               end else if (tick && ch_mask != 4'b0) begin
                  mask_q      <= ch_mask & ~(4'b0001 << tick_ch);
                  ch          <= tick_ch;
                  adc.adc_mux <= {1'b1, tick_ch};
                  frame_bad   <= 1'b0;
                  busy        <= 1'b1;
                  state       <= SELECT;
               end
            end
            SELECT: begin
               adc.adc_start <= 1'b1;
               state         <= ISSUE;
            end
            ISSUE: begin
               to_cnt <= '0;
               state  <= WAIT_DONE;
            end
            WAIT_DONE: begin
               to_cnt <= to_cnt + 1'b1;
               if (done_evt) sample_bus[{ch, 4'b0000} +: 16] <= adc.adc_data;
               if (to_evt) begin
                  timeout_err <= 1'b1;
                  err_ch      <= ch;
                  frame_bad   <= 1'b1;
               end
               if (done_evt || to_evt) begin
                  if (!run) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else if (mask_q != 4'b0) begin
                     mask_q      <= mask_q & ~(4'b0001 << next_ch);
                     ch          <= next_ch;
                     adc.adc_mux <= {1'b1, next_ch};
                     state       <= SELECT;
                  end else begin
                     frame_valid <= 1'b1;
                     frame_ok    <= ~(frame_bad | to_evt);
                     frame_cnt   <= frame_cnt + 1'b1;
                     state       <= FRAME_END;
                  end
               end
            end
            FRAME_END: begin
               busy  <= 1'b0;
               state <= WAIT_TICK;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb/tb_adc_sample_scheduler.sv - randomized self-checking bench for adc_sample_scheduler
module tb_adc_sample_scheduler;
   localparam int P  = 16;
   localparam int TO = 8;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic [3:0]  ch_mask;
   logic        clr_err;
   logic [63:0] sample_bus;
   logic        frame_valid;
   logic        frame_ok;
   logic [15:0] frame_cnt;
   logic        timeout_err;
   logic [1:0]  err_ch;
   logic        overrun_err;
   logic        busy;

   adc_sample_scheduler_if ifc ();

   adc_sample_scheduler #(.PERIOD_CYC(P), .TIMEOUT_CYC(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .ch_mask     (ch_mask),
      .clr_err     (clr_err),
      .adc         (ifc),
      .sample_bus  (sample_bus),
      .frame_valid (frame_valid),
      .frame_ok    (frame_ok),
      .frame_cnt   (frame_cnt),
      .timeout_err (timeout_err),
      .err_ch      (err_ch),
      .overrun_err (overrun_err),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { int cyc; logic [1:0] ch; int lat; logic [15:0] data; } st_ent_t;
   typedef struct { int cyc; logic ok; } fv_ent_t;

   // transaction-level model: each tick expands into a timeline of expected starts and frame end
   st_ent_t     q_st[$];
   fv_ent_t     q_fv[$];
   logic [15:0] exp_bus [4];
   logic [15:0] exp_cnt;
   int          first_to, first_ov, fs, fe, t_run, cyc, mode;
   logic [1:0]  last_to_ch;
   bit          model_on, drain;
   int          rd_rem;
   logic [1:0]  rd_ch;
   logic [15:0] rd_data;
   int          n_total = 0;
   int          n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) exp_bus[i] = 16'h0;
      exp_cnt = 16'h0; first_to = 32'h7fffffff; first_ov = 32'h7fffffff;
      fs = 1; fe = 0; last_to_ch = 2'd0; rd_rem = 0;
      q_st.delete(); q_fv.delete();
   endtask

   function automatic int pick_lat();
      case (mode)
         0, 1:    return 1;
         2, 4:    return 0;
         default: return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO)) : int'($urandom_range(1, 2));
      endcase
   endfunction

   task automatic step();
      logic    exp_st, exp_fv, ok;
      st_ent_t se, ne;
      fv_ent_t fv, nf;
      int      t, w;
      @(posedge clk);
      #1;
      cyc++;
      if (!model_on) return;
      exp_st = 1'b0;
      exp_fv = 1'b0;
      if (q_st.size() > 0) if (q_st[0].cyc == cyc) begin exp_st = 1'b1; se = q_st.pop_front(); end
      if (q_fv.size() > 0) if (q_fv[0].cyc == cyc) begin exp_fv = 1'b1; fv = q_fv.pop_front(); end
      check_eq("adc_start", ifc.adc_start, exp_st);
      if (exp_st) check_eq("adc_mux", ifc.adc_mux, {1'b1, se.ch});
      check_eq("busy", busy, (cyc >= fs && cyc <= fe));
      check_eq("frame_valid", frame_valid, exp_fv);
      if (exp_fv) begin
         exp_cnt = exp_cnt + 16'h1;
         check_eq("frame_ok", frame_ok, fv.ok);
         check_eq("frame_cnt", frame_cnt, exp_cnt);
         check_eq("sample_bus", sample_bus, {exp_bus[3], exp_bus[2], exp_bus[1], exp_bus[0]});
         check_eq("timeout_err", timeout_err, first_to < cyc);
         check_eq("overrun_err", overrun_err, first_ov < cyc);
         if (first_to < cyc) check_eq("err_ch", err_ch, last_to_ch);
      end
      // reader: answer a start after its drawn latency (0 = never answers)
      ifc.adc_done = 1'b0;
      ifc.adc_data = 16'($urandom);
      if (rd_rem > 0) begin
         rd_rem--;
         if (rd_rem == 0) begin
            ifc.adc_done = 1'b1; ifc.adc_data = rd_data; exp_bus[rd_ch] = rd_data;
         end
      end
      if (exp_st) begin rd_rem = se.lat; rd_ch = se.ch; rd_data = se.data; end
      case (drain ? -1 : mode)
         -1:      ch_mask = 4'b0000;
         0, 4:    ch_mask = 4'b0011;
         1:       ch_mask = 4'b1010;
         2:       ch_mask = 4'b0010;
         default: ch_mask = 4'($urandom);
      endcase
      if (run && ((cyc - t_run) % P) == P - 1) begin
         if (cyc <= fe) begin
            if (cyc < first_ov) first_ov = cyc;
         end else if (ch_mask != 4'b0) begin
            t = cyc + 1; ok = 1'b1; fs = t;
            for (int c = 0; c < 4; c++) if (ch_mask[c]) begin
               ne.cyc = t + 1; ne.ch = 2'(c); ne.lat = pick_lat();
               ne.data = (mode == 0 && c == 0) ? 16'h1234 : (mode == 0 && c == 1) ? 16'hABCD : 16'($urandom);
               q_st.push_back(ne);
               if (ne.lat == 0) begin
                  ok = 1'b0; w = TO; last_to_ch = 2'(c);
                  if (t + 1 + TO < first_to) first_to = t + 1 + TO;
               end else w = ne.lat;
               t += 2 + w;
            end
            fe = t; nf.cyc = t; nf.ok = ok; q_fv.push_back(nf);
         end
      end
   endtask

   task automatic run_phase(input int m, input int n);
      int guard;
      mode = m; drain = 0; model_on = 1; run = 1'b1; t_run = cyc;
      repeat (n) step();
      drain = 1; guard = 0;
      while ((cyc <= fe || q_st.size() > 0 || q_fv.size() > 0 || rd_rem > 0) && guard < 400) begin
         step(); guard++;
      end
      check_eq("phase_drain", guard >= 400, 0);
      run = 1'b0;
      step(); step();
      model_on = 0;
   endtask

   task automatic wait_start(input int max_cyc, output int at);
      at = -1;
      for (int i = 0; i < max_cyc; i++) begin
         step();
         if (ifc.adc_start) begin at = cyc; break; end
      end
      check_eq("start_seen", at >= 0, 1);
   endtask

   task automatic clear_errs();
      clr_err = 1'b1; step(); clr_err = 1'b0;
      check_eq("clr_timeout", timeout_err, 0);
      check_eq("clr_overrun", overrun_err, 0);
      first_to = 32'h7fffffff; first_ov = 32'h7fffffff;
   endtask

   task automatic check_zero(input string pfx);
      check_eq({pfx, "_start"}, ifc.adc_start, 0);
      check_eq({pfx, "_mux"}, ifc.adc_mux, 0);
      check_eq({pfx, "_bus"}, sample_bus, 0);
      check_eq({pfx, "_fv"}, frame_valid, 0);
      check_eq({pfx, "_ok"}, frame_ok, 0);
      check_eq({pfx, "_cnt"}, frame_cnt, 0);
      check_eq({pfx, "_to"}, timeout_err, 0);
      check_eq({pfx, "_errch"}, err_ch, 0);
      check_eq({pfx, "_ov"}, overrun_err, 0);
      check_eq({pfx, "_busy"}, busy, 0);
   endtask

   initial begin
      int c, s;
      bit seen_fv;
      cyc = 0; model_on = 0; drain = 0; mode = 0; t_run = 0;
      rst_n = 1'b0; run = 1'b0; ch_mask = 4'b0; clr_err = 1'b0;
      ifc.adc_done = 1'b0; ifc.adc_data = 16'h0;
      model_reset();
      repeat (3) step();
      rst_n = 1'b1;
      step();
      check_zero("reset");

      run_phase(0, 20);
      check_eq("basic_bus", sample_bus[31:0], 32'hABCD1234);
      check_eq("basic_cnt", frame_cnt, 1);

      run_phase(1, 20);
      check_eq("sparse_ch0", sample_bus[15:0], 16'h1234);
      check_eq("sparse_ch2", sample_bus[47:32], 16'h0000);

      run_phase(2, 20);
      check_eq("to_err", timeout_err, 1);
      check_eq("to_ch", err_ch, 1);
      check_eq("to_keep", sample_bus[31:16], exp_bus[1]);
      clear_errs();

      run_phase(4, 40);
      check_eq("overrun", overrun_err, 1);
      clear_errs();

      run_phase(3, 800);
      clear_errs();

      // drop run while waiting for a conversion, then answer it
      ch_mask = 4'b0001; run = 1'b1; c = cyc;
      wait_start(40, s);
      check_eq("first_start_delay", s - c, P + 1);
      step();
      step(); run = 1'b0;
      step(); ifc.adc_done = 1'b1; ifc.adc_data = 16'h5A5A; exp_bus[0] = 16'h5A5A;
      step(); ifc.adc_done = 1'b0;
      check_eq("drop_store", sample_bus[15:0], 16'h5A5A);
      check_eq("drop_busy", busy, 0);
      seen_fv = frame_valid;
      repeat (5) begin step(); seen_fv |= frame_valid; end
      check_eq("drop_no_fv", seen_fv, 0);
      check_eq("drop_cnt", frame_cnt, exp_cnt);

      ch_mask = 4'b0010; run = 1'b1; c = cyc;
      wait_start(40, s);
      check_eq("restart_delay", s - c, P + 1);
      check_eq("restart_mux", ifc.adc_mux, 3'b101);

      // reset during the wait, then a late done
      step(); rst_n = 1'b0; run = 1'b0;
      step(); rst_n = 1'b1;
      check_zero("midrst");
      step(); ifc.adc_done = 1'b1; ifc.adc_data = 16'hBEEF;
      step(); ifc.adc_done = 1'b0;
      check_zero("late_done");
      model_reset();

      force dut.frame_cnt = 16'hFFFE;
      #1;
      release dut.frame_cnt;
      exp_cnt = 16'hFFFE;
      run_phase(0, 40);
      check_eq("cnt_wrap", frame_cnt, 16'h0000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
